// File: rtl/cmd_faims_pkg.sv
// Shared constants for the FAIMS command decoder: command ids, message bit
// positions and the field widths of the parameter banks.
package cmd_faims_pkg;

    localparam int MSG_W   = 64;
    localparam int CMD_W   = 8;
    localparam int VC_W    = 12;
    localparam int FAIMS_W = 16;
    localparam int SKIP_W  = 8;

    localparam logic [CMD_W-1:0] CMD_FLAGS = 8'h01;
    localparam logic [CMD_W-1:0] CMD_VC    = 8'h02;
    localparam logic [CMD_W-1:0] CMD_FAIMS = 8'h04;

    // Flag bits are indexed by their position in the message word.
    localparam int FLAG_SWEEP_ON     = 8;
    localparam int FLAG_SHUTDOWN     = 9;
    localparam int FLAG_IONIZE       = 10;
    localparam int FLAG_POS          = 11;
    localparam int FLAG_NEG          = 12;
    localparam int FLAG_PUMP_ON      = 13;
    localparam int FLAG_SWEEP_UP     = 14;
    localparam int FLAG_ATTENTION    = 15;
    localparam int FLAG_FAIMS_ENABLE = 16;

    localparam int VC_STEP_LSB    = 8;
    localparam int VC_REPEATS_LSB = 20;
    localparam int VC_START_LSB   = 32;
    localparam int VC_STEPS_LSB   = 44;

    localparam int FAIMS_COIL_LSB   = 8;
    localparam int FAIMS_PERIOD_LSB = 24;
    localparam int FAIMS_PULSE_LSB  = 40;
    localparam int FAIMS_SKIPS_LSB  = 56;

    typedef struct packed {
        logic up;
        logic down;
        logic au;
        logic ad;
        logic bu;
        logic bd;
    } faims_drive_t;

endpackage

// File: rtl/cmd_faims_ctrl_wavegen.sv
// FAIMS waveform generator: period/skip counters and the registered HV and
// H-bridge coil switch drives.
module faims_wavegen
    import cmd_faims_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               restart_i,
    input  logic [FAIMS_W-1:0] coil_i,
    input  logic [FAIMS_W-1:0] period_i,
    input  logic [FAIMS_W-1:0] pulse_i,
    input  logic [SKIP_W-1:0]  skips_i,
    output faims_drive_t       drive_o
);

    logic [FAIMS_W-1:0] cnt_q, cnt_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic               pol_q, pol_d;
    logic               started_q, started_d;
    faims_drive_t       drive_q, drive_d;

    logic               run;
    logic               wrap;
    logic               coil_on;
    logic [FAIMS_W-1:0] period_m1;
    logic [FAIMS_W-1:0] coil_lim;
    logic [FAIMS_W:0]   down_thr;

    always_comb begin
        run       = enable_i && (period_i >= 16'd2);
        period_m1 = period_i - 16'd1;
        coil_lim  = (coil_i < period_m1) ? coil_i : period_m1;
        down_thr  = {1'b0, pulse_i} + 17'd1;
        wrap      = (cnt_q >= period_m1);

        cnt_d     = '0;
        skip_d    = '0;
        pol_d     = 1'b0;
        started_d = 1'b0;
        drive_d   = '0;
        coil_on   = 1'b0;

        if (run) begin
            started_d = 1'b1;
            // First cycle after enabling or after a parameter load starts at cnt=0.
            if (!restart_i && started_q) begin
                if (wrap) begin
                    cnt_d = '0;
                    if (skip_q == '0) begin
                        pol_d  = ~pol_q;
                        skip_d = skips_i;
                    end else begin
                        pol_d  = pol_q;
                        skip_d = skip_q - 8'd1;
                    end
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                    skip_d = skip_q;
                    pol_d  = pol_q;
                end
            end

            coil_on      = (skip_d == '0) && (cnt_d < coil_lim);
            drive_d.up   = (cnt_d < pulse_i);
            drive_d.down = ({1'b0, cnt_d} >= down_thr);
            drive_d.au   = coil_on && !pol_d;
            drive_d.bd   = coil_on && !pol_d;
            drive_d.bu   = coil_on && pol_d;
            drive_d.ad   = coil_on && pol_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            skip_q    <= '0;
            pol_q     <= 1'b0;
            started_q <= 1'b0;
            drive_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            pol_q     <= pol_d;
            started_q <= started_d;
            drive_q   <= drive_d;
        end
    end

    assign drive_o = drive_q;

endmodule

// File: rtl/cmd_faims_ctrl.sv
// Decodes SPI command words into flag, Vc sweep and FAIMS parameter banks
// and drives the FAIMS waveform generator from them.
module cmd_faims_ctrl
    import cmd_faims_pkg::*;
(
    input  logic               CLK,
    input  logic               i_reset,
    input  logic               i_shiftedIn,
    input  logic [MSG_W-1:0]   i_mem,
    output logic               o_parFlag_sweepOn,
    output logic               o_parFlag_shutdown,
    output logic               o_parFlag_ionize,
    output logic               o_parFlag_pos,
    output logic               o_parFlag_neg,
    output logic               o_parFlag_pumpOn,
    output logic               o_parFlag_sweepUp,
    output logic               o_parFlag_attention,
    output logic               o_parFlag_faimsEnable,
    output logic               o_vcReset,
    output logic [VC_W-1:0]    o_parVc_step,
    output logic [VC_W-1:0]    o_parVc_repeats,
    output logic [VC_W-1:0]    o_parVc_start,
    output logic [VC_W-1:0]    o_parVc_steps,
    output logic               o_faimsReset,
    output logic [FAIMS_W-1:0] o_parFaims_coil,
    output logic [FAIMS_W-1:0] o_parFaims_period,
    output logic [FAIMS_W-1:0] o_parFaims_pulse,
    output logic [SKIP_W-1:0]  o_parFaims_skips,
    output logic               o_faimsUp,
    output logic               o_faimsDown,
    output logic               o_coilAU,
    output logic               o_coilAD,
    output logic               o_coilBU,
    output logic               o_coilBD
);

    logic                                    sq_q;
    logic                                    strobe;
    logic [FLAG_FAIMS_ENABLE:FLAG_SWEEP_ON]  flags_q, flags_d;
    logic [VC_W-1:0]    vc_step_q, vc_step_d, vc_repeats_q, vc_repeats_d;
    logic [VC_W-1:0]    vc_start_q, vc_start_d, vc_steps_q, vc_steps_d;
    logic [FAIMS_W-1:0] fa_coil_q, fa_coil_d, fa_period_q, fa_period_d;
    logic [FAIMS_W-1:0] fa_pulse_q, fa_pulse_d;
    logic [SKIP_W-1:0]  fa_skips_q, fa_skips_d;
    logic               vc_reset_q, vc_reset_d, fa_reset_q, fa_reset_d;
    faims_drive_t       drive;

    // A command is taken once, on the cycle i_shiftedIn rises; holding it high
    // does not re-trigger.
    always_comb begin
        strobe       = i_shiftedIn && !sq_q;
        flags_d      = flags_q;
        vc_step_d    = vc_step_q;
        vc_repeats_d = vc_repeats_q;
        vc_start_d   = vc_start_q;
        vc_steps_d   = vc_steps_q;
        fa_coil_d    = fa_coil_q;
        fa_period_d  = fa_period_q;
        fa_pulse_d   = fa_pulse_q;
        fa_skips_d   = fa_skips_q;
        vc_reset_d   = 1'b0;
        fa_reset_d   = 1'b0;

        if (strobe) begin
            case (i_mem[CMD_W-1:0])
                CMD_FLAGS: flags_d = i_mem[FLAG_FAIMS_ENABLE:FLAG_SWEEP_ON];
                CMD_VC: begin
                    vc_step_d    = i_mem[VC_STEP_LSB    +: VC_W];
                    vc_repeats_d = i_mem[VC_REPEATS_LSB +: VC_W];
                    vc_start_d   = i_mem[VC_START_LSB   +: VC_W];
                    vc_steps_d   = i_mem[VC_STEPS_LSB   +: VC_W];
                    vc_reset_d   = 1'b1;
                end
                CMD_FAIMS: begin
                    fa_coil_d   = i_mem[FAIMS_COIL_LSB   +: FAIMS_W];
                    fa_period_d = i_mem[FAIMS_PERIOD_LSB +: FAIMS_W];
                    fa_pulse_d  = i_mem[FAIMS_PULSE_LSB  +: FAIMS_W];
                    fa_skips_d  = i_mem[FAIMS_SKIPS_LSB  +: SKIP_W];
                    fa_reset_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (i_reset) begin
            sq_q         <= 1'b0;
            flags_q      <= '0;
            vc_step_q    <= '0;
            vc_repeats_q <= '0;
            vc_start_q   <= '0;
            vc_steps_q   <= '0;
            fa_coil_q    <= '0;
            fa_period_q  <= '0;
            fa_pulse_q   <= '0;
            fa_skips_q   <= '0;
            vc_reset_q   <= 1'b0;
            fa_reset_q   <= 1'b0;
        end else begin
            sq_q         <= i_shiftedIn;
            flags_q      <= flags_d;
            vc_step_q    <= vc_step_d;
            vc_repeats_q <= vc_repeats_d;
            vc_start_q   <= vc_start_d;
            vc_steps_q   <= vc_steps_d;
            fa_coil_q    <= fa_coil_d;
            fa_period_q  <= fa_period_d;
            fa_pulse_q   <= fa_pulse_d;
            fa_skips_q   <= fa_skips_d;
            vc_reset_q   <= vc_reset_d;
            fa_reset_q   <= fa_reset_d;
        end
    end

    faims_wavegen u_wavegen (
        .clk_i     (CLK),
        .rst_i     (i_reset),
        .enable_i  (flags_q[FLAG_FAIMS_ENABLE]),
        .restart_i (fa_reset_q),
        .coil_i    (fa_coil_q),
        .period_i  (fa_period_q),
        .pulse_i   (fa_pulse_q),
        .skips_i   (fa_skips_q),
        .drive_o   (drive)
    );

    assign o_parFlag_sweepOn     = flags_q[FLAG_SWEEP_ON];
    assign o_parFlag_shutdown    = flags_q[FLAG_SHUTDOWN];
    assign o_parFlag_ionize      = flags_q[FLAG_IONIZE];
    assign o_parFlag_pos         = flags_q[FLAG_POS];
    assign o_parFlag_neg         = flags_q[FLAG_NEG];
    assign o_parFlag_pumpOn      = flags_q[FLAG_PUMP_ON];
    assign o_parFlag_sweepUp     = flags_q[FLAG_SWEEP_UP];
    assign o_parFlag_attention   = flags_q[FLAG_ATTENTION];
    assign o_parFlag_faimsEnable = flags_q[FLAG_FAIMS_ENABLE];

    assign o_vcReset       = vc_reset_q;
    assign o_parVc_step    = vc_step_q;
    assign o_parVc_repeats = vc_repeats_q;
    assign o_parVc_start   = vc_start_q;
    assign o_parVc_steps   = vc_steps_q;

    assign o_faimsReset      = fa_reset_q;
    assign o_parFaims_coil   = fa_coil_q;
    assign o_parFaims_period = fa_period_q;
    assign o_parFaims_pulse  = fa_pulse_q;
    assign o_parFaims_skips  = fa_skips_q;

    assign o_faimsUp   = drive.up;
    assign o_faimsDown = drive.down;
    assign o_coilAU    = drive.au;
    assign o_coilAD    = drive.ad;
    assign o_coilBU    = drive.bu;
    assign o_coilBD    = drive.bd;

endmodule

// File: tb/tb_cmd_faims_ctrl.sv
// Directed bench for cmd_faims_ctrl: table of command words with expected
// register banks, plus waveform sequences checked against a period/skip model.
module tb_cmd_faims_ctrl;

    logic        CLK;
    logic        i_reset;
    logic        i_shiftedIn;
    logic [63:0] i_mem;
    logic        o_parFlag_sweepOn, o_parFlag_shutdown, o_parFlag_ionize;
    logic        o_parFlag_pos, o_parFlag_neg, o_parFlag_pumpOn;
    logic        o_parFlag_sweepUp, o_parFlag_attention, o_parFlag_faimsEnable;
    logic        o_vcReset;
    logic [11:0] o_parVc_step, o_parVc_repeats, o_parVc_start, o_parVc_steps;
    logic        o_faimsReset;
    logic [15:0] o_parFaims_coil, o_parFaims_period, o_parFaims_pulse;
    logic [7:0]  o_parFaims_skips;
    logic        o_faimsUp, o_faimsDown, o_coilAU, o_coilAD, o_coilBU, o_coilBD;

    int checks   = 0;
    int failures = 0;

    cmd_faims_ctrl dut (
        .CLK                   (CLK),
        .i_reset               (i_reset),
        .i_shiftedIn           (i_shiftedIn),
        .i_mem                 (i_mem),
        .o_parFlag_sweepOn     (o_parFlag_sweepOn),
        .o_parFlag_shutdown    (o_parFlag_shutdown),
        .o_parFlag_ionize      (o_parFlag_ionize),
        .o_parFlag_pos         (o_parFlag_pos),
        .o_parFlag_neg         (o_parFlag_neg),
        .o_parFlag_pumpOn      (o_parFlag_pumpOn),
        .o_parFlag_sweepUp     (o_parFlag_sweepUp),
        .o_parFlag_attention   (o_parFlag_attention),
        .o_parFlag_faimsEnable (o_parFlag_faimsEnable),
        .o_vcReset             (o_vcReset),
        .o_parVc_step          (o_parVc_step),
        .o_parVc_repeats       (o_parVc_repeats),
        .o_parVc_start         (o_parVc_start),
        .o_parVc_steps         (o_parVc_steps),
        .o_faimsReset          (o_faimsReset),
        .o_parFaims_coil       (o_parFaims_coil),
        .o_parFaims_period     (o_parFaims_period),
        .o_parFaims_pulse      (o_parFaims_pulse),
        .o_parFaims_skips      (o_parFaims_skips),
        .o_faimsUp             (o_faimsUp),
        .o_faimsDown           (o_faimsDown),
        .o_coilAU              (o_coilAU),
        .o_coilAD              (o_coilAD),
        .o_coilBU              (o_coilBU),
        .o_coilBD              (o_coilBD)
    );

    // Clock / watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observation helpers (packing order fixed by the bench)
    function automatic logic [63:0] obs_flags();
        return 64'({o_parFlag_faimsEnable, o_parFlag_attention, o_parFlag_sweepUp,
                    o_parFlag_pumpOn, o_parFlag_neg, o_parFlag_pos,
                    o_parFlag_ionize, o_parFlag_shutdown, o_parFlag_sweepOn});
    endfunction

    function automatic logic [63:0] obs_vc();
        return 64'({o_parVc_steps, o_parVc_start, o_parVc_repeats, o_parVc_step});
    endfunction

    function automatic logic [63:0] obs_faims();
        return 64'({o_parFaims_skips, o_parFaims_pulse, o_parFaims_period, o_parFaims_coil});
    endfunction

    function automatic logic [63:0] obs_drive();
        return 64'({o_faimsUp, o_faimsDown, o_coilAU, o_coilAD, o_coilBU, o_coilBD});
    endfunction

    // Reference drive for cycle k after a (re)start: period index decides
    // active/skipped and polarity, position in period decides HV/coil state.
    function automatic logic [5:0] model_drive(int k, int coil, int period, int pulse, int skips);
        int   c, p, lim;
        logic act, pol, drv;
        c   = k % period;
        p   = k / period;
        act = ((p % (skips + 1)) == 0);
        pol = (((p / (skips + 1)) % 2) == 1);
        lim = (coil < period - 1) ? coil : period - 1;
        drv = act && (c < lim);
        return {(c < pulse), (c > pulse), drv && !pol, drv && pol, drv && pol, drv && !pol};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe a command; returns {vcReset,faimsReset} on the accept cycle and the one after.
    task automatic send_cmd(input logic [63:0] mem, output logic [3:0] pulses);
        i_mem       = mem;
        i_shiftedIn = 1'b1;
        tick();
        pulses[3:2] = {o_vcReset, o_faimsReset};
        i_shiftedIn = 1'b0;
        tick();
        pulses[1:0] = {o_vcReset, o_faimsReset};
    endtask

    task automatic check_wave(input string name, input int n, input int coil,
                              input int period, input int pulse, input int skips);
        for (int k = 0; k < n; k++) begin
            check(name, obs_drive(), 64'(model_drive(k, coil, period, pulse, skips)));
            tick();
        end
    endtask

    // Command table
    typedef struct {
        logic [63:0] mem;
        logic [8:0]  flags;   // {faimsEnable..sweepOn}
        logic [47:0] vc;      // {steps,start,repeats,step}
        logic [55:0] faims;   // {skips,pulse,period,coil}
        logic [1:0]  pulses;  // {vcReset,faimsReset}
    } vec_t;

    vec_t        vecs[8];
    logic [3:0]  pl;
    logic [63:0] rnd;
    int          vc_pulses, fa_pulses;

    initial begin
        // zero command, flags, Vc load, ignored ids, all-ones flags, restore flags
        vecs[0] = '{64'h0000_0000_0000_0000, 9'h000, 48'h0,               56'h0, 2'b00};
        vecs[1] = '{64'h0000_0000_0001_4101, 9'h141, 48'h0,               56'h0, 2'b00};
        vecs[2] = '{64'h0017_C800_0800_0102, 9'h141, 48'h17C_800_080_001, 56'h0, 2'b10};
        vecs[3] = '{64'hDEAD_BEEF_1234_5607, 9'h141, 48'h17C_800_080_001, 56'h0, 2'b00};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FF00, 9'h141, 48'h17C_800_080_001, 56'h0, 2'b00};
        vecs[5] = '{64'h1234_5678_9ABC_DE03, 9'h141, 48'h17C_800_080_001, 56'h0, 2'b00};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FF01, 9'h1FF, 48'h17C_800_080_001, 56'h0, 2'b00};
        vecs[7] = '{64'h0000_0000_0001_4101, 9'h141, 48'h17C_800_080_001, 56'h0, 2'b00};

        i_reset     = 1'b1;
        i_shiftedIn = 1'b0;
        i_mem       = '0;
        tick();
        tick();
        check("rst_flags", obs_flags(), 64'h0);
        check("rst_vc", obs_vc(), 64'h0);
        check("rst_faims", obs_faims(), 64'h0);
        check("rst_drive", obs_drive(), 64'h0);
        check("rst_pulses", 64'({o_vcReset, o_faimsReset}), 64'h0);
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            send_cmd(vecs[i].mem, pl);
            check($sformatf("vec%0d_pulses", i), 64'(pl), 64'({vecs[i].pulses, 2'b00}));
            check($sformatf("vec%0d_flags", i), obs_flags(), 64'(vecs[i].flags));
            check($sformatf("vec%0d_vc", i), obs_vc(), 64'(vecs[i].vc));
            check($sformatf("vec%0d_faims", i), obs_faims(), 64'(vecs[i].faims));
            check($sformatf("vec%0d_drive", i), obs_drive(), 64'h0);
        end

        // coil=3 period=10 pulse=5 skips=0
        send_cmd({8'd0, 16'd5, 16'd10, 16'd3, 8'h04}, pl);
        check("fa1_pulses", 64'(pl), 64'h4);
        check("fa1_regs", obs_faims(), 64'h00_0005_000A_0003);
        check_wave("fa1_wave", 40, 3, 10, 5, 0);

        // same timing, skips=2
        send_cmd({8'd2, 16'd5, 16'd10, 16'd3, 8'h04}, pl);
        check("fa2_pulses", 64'(pl), 64'h4);
        check("fa2_regs", obs_faims(), 64'h02_0005_000A_0003);
        check_wave("fa2_wave", 60, 3, 10, 5, 2);

        // pulse=0xFFFF beyond period: no down phase, coil limited by period-1
        send_cmd({8'd0, 16'hFFFF, 16'd4, 16'hFFFF, 8'h04}, pl);
        check("fa3_pulses", 64'(pl), 64'h4);
        check_wave("fa3_wave", 12, 16'hFFFF, 4, 16'hFFFF, 0);

        // pulse = period-1: up drops only at cnt=pulse
        send_cmd({8'd1, 16'd5, 16'd6, 16'd2, 8'h04}, pl);
        check("fa4_pulses", 64'(pl), 64'h4);
        check_wave("fa4_wave", 24, 2, 6, 5, 1);

        // clearing faimsEnable forces drives low; re-enabling restarts at cnt=0
        send_cmd(64'h0000_0000_0000_4101, pl);
        check("dis_flags", obs_flags(), 64'h041);
        for (int k = 0; k < 4; k++) begin
            check("dis_drive", obs_drive(), 64'h0);
            tick();
        end
        send_cmd(64'h0000_0000_0001_4101, pl);
        check("en_pulses", 64'(pl), 64'h0);
        check_wave("en_wave", 12, 2, 6, 5, 1);

        // strobe held high for 100 cycles triggers a single load
        i_mem       = 64'h0000_5006_0070_0802;
        i_shiftedIn = 1'b1;
        vc_pulses   = 0;
        fa_pulses   = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            vc_pulses += int'(o_vcReset);
            fa_pulses += int'(o_faimsReset);
        end
        i_shiftedIn = 1'b0;
        tick();
        check("hold_vc_pulses", 64'(vc_pulses), 64'd1);
        check("hold_fa_pulses", 64'(fa_pulses), 64'd0);
        check("hold_vc", obs_vc(), 64'h005_006_007_008);

        // unknown id with random payload leaves everything alone
        rnd = {$urandom(), $urandom()};
        rnd[7:0] = 8'h07;
        send_cmd(rnd, pl);
        check("unk_pulses", 64'(pl), 64'h0);
        check("unk_flags", obs_flags(), 64'h141);
        check("unk_vc", obs_vc(), 64'h005_006_007_008);
        check("unk_faims", obs_faims(), 64'h01_0005_0006_0002);

        // mid-run reset clears every output on the next cycle
        tick();
        i_reset = 1'b1;
        tick();
        check("mrst_flags", obs_flags(), 64'h0);
        check("mrst_vc", obs_vc(), 64'h0);
        check("mrst_faims", obs_faims(), 64'h0);
        check("mrst_drive", obs_drive(), 64'h0);
        check("mrst_pulses", 64'({o_vcReset, o_faimsReset}), 64'h0);
        i_reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_faims_ctrl.md
Name: cmd_faims_ctrl

Overview:
- Decodes 64-bit command words from the SPI receive shift register into registered flag, Vc sweep and FAIMS parameter banks.
- Drives the FAIMS waveform generator: high-voltage up/down switches plus H-bridge DCDC coil drive.
- Sits between the SPI slave (supplies `i_mem` and the `i_shiftedIn` strobe) and the analog front-end switches.

Parameters:
- None. All widths are fixed: 64-bit message, 12-bit Vc fields, 16-bit FAIMS timing, 8-bit skip count.

Ports:
- CLK  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_shiftedIn  in  1  high while `i_mem` holds a complete message; its rising edge triggers decode
- i_mem  in  64  message; `[7:0]` = command id, last byte shifted in (MSB-first shifting)
- o_parFlag_sweepOn, o_parFlag_shutdown, o_parFlag_ionize, o_parFlag_pos, o_parFlag_neg, o_parFlag_pumpOn, o_parFlag_sweepUp, o_parFlag_attention, o_parFlag_faimsEnable  out  1 each  flag registers
- o_vcReset  out  1  one-cycle pulse on Vc parameter load
- o_parVc_step, o_parVc_repeats, o_parVc_start, o_parVc_steps  out  12 each
- o_faimsReset  out  1  one-cycle pulse on FAIMS parameter load
- o_parFaims_coil, o_parFaims_period, o_parFaims_pulse  out  16 each
- o_parFaims_skips  out  8
- o_faimsUp, o_faimsDown, o_coilAU, o_coilAD, o_coilBU, o_coilBD  out  1 each  switch drives

Behaviour:
- Reset: all registers, counters and outputs go to 0.
- Strobe detection:
  - Register `i_shiftedIn` into `sq`.
  - A command is accepted at the edge where `i_shiftedIn=1` and `sq=0`.
  - Decoded registers are visible the cycle after that edge.
  - Holding `i_shiftedIn` high does not re-trigger.
- Command 0x01, flags:
  - Bit map: `[8]` sweepOn, `[9]` shutdown, `[10]` ionize, `[11]` pos, `[12]` neg, `[13]` pumpOn, `[14]` sweepUp, `[15]` attention, `[16]` faimsEnable.
  - All nine flags are overwritten; `[63:17]` are ignored.
- Command 0x02, Vc sweep:
  - Field map: step = `[19:8]`, repeats = `[31:20]`, start = `[43:32]`, steps = `[55:44]`.
  - `o_vcReset` pulses high for exactly one cycle, coincident with the new values.
- Command 0x04, FAIMS timing:
  - Field map: coil = `[23:8]`, period = `[39:24]`, pulse = `[55:40]`, skips = `[63:56]`.
  - `o_faimsReset` pulses for one cycle, coincident with the new values.
- Any other command id (including 0x00): ignored; no register changes, no pulses.
- FAIMS generator, registered outputs:
  - Runs only when faimsEnable=1 and period≥2.
  - Otherwise all six drive outputs are 0 and counters are held at 0.
  - The internal faimsReset pulse, or i_reset, clears the period counter `cnt`, the skip counter and the polarity bit.
- Period counter: `cnt` counts 0..period-1, then wraps to 0; each wrap completes one period.
- HV drive:
  - `o_faimsUp` = (cnt < pulse).
  - `o_faimsDown` = (cnt ≥ pulse+1), leaving 1 cycle of dead time at cnt = pulse.
  - If pulse ≥ period-1, faimsDown stays 0 and faimsUp stays 1 except while cnt = pulse.
  - `o_faimsUp` and `o_faimsDown` are never high together.
- Coil drive, active and skipped periods:
  - After each active period, `skips` periods follow with all coil outputs 0; then the next active period starts.
  - skips=0 means every period is active.
- Coil drive within an active period:
  - Coil is driven while cnt < min(coil, period-1).
  - Polarity bit 0: AU and BD high. Polarity bit 1: BU and AD high.
  - Polarity toggles at the end of each active period.
  - AU&AD and BU&BD are never high together.
- Parameter change mid-period:
  - New values take effect immediately, because a 0x04 command also restarts via faimsReset.
  - A 0x01 command clearing faimsEnable forces outputs low on the next cycle.
- Arithmetic: compares are unsigned at 16 bits. The pulse+1 compare uses a 17-bit width, so pulse = 0xFFFF cannot wrap.

Decomposition:
- Package `cmd_faims_pkg` holds:
  - command id constants: CMD_FLAGS=8'h01, CMD_VC=8'h02, CMD_FAIMS=8'h04;
  - flag bit-index constants;
  - field width constants.
- One sub-module, `faims_wavegen`: the counters plus HV and coil drive, fed from the parameter registers.

Test Plan:
- Reset, then mem=0 with a strobe: all outputs stay 0 and no reset pulses occur.
- mem=64'h0000_0000_0001_4101 with a strobe:
  - flags: sweepOn=1, sweepUp=1, faimsEnable=1, all others 0;
  - generator stays idle because period=0.
- CMD_FAIMS with coil=3, period=10, pulse=5, skips=0:
  - one-cycle o_faimsReset;
  - faimsUp high for 5 cycles, 1 cycle dead, faimsDown high for 4 cycles, repeating every 10 cycles;
  - AU/BD high for cnt 0..2 in one period, BU/AD high for cnt 0..2 in the next.
- Same command with skips=2: coil drive occurs in every third period only, still alternating polarity; the HV waveform is unchanged.
- CMD_VC with step=0x001, repeats=0x080, start=0x800, steps=0x17C:
  - values appear one cycle after the strobe edge, with a one-cycle o_vcReset;
  - holding i_shiftedIn high for 100 cycles gives no second pulse.
- Unknown command id 0x07 with random payload: all registers unchanged; a mid-run i_reset clears every output next cycle.
